// File: rtl/serial_frame_source.sv
// Parallel-to-serial frame source: shifts each accepted word out LSB-first with frame strobes and an idle gap.
// Optional trailing even-parity bit when SER_PARITY_BIT_EN is defined.
module serial_frame_source #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
    localparam logic [3:0] GAP_LOAD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
`ifdef SER_PARITY_BIT_EN
        ,
        PAR   = 2'd3
`endif
    } state_t;

    localparam state_t EXIT = (GAP_CYCLES > 0) ? GAP : IDLE;

    state_t state;
    state_t nxt;

    logic [WIDTH-1:0] sreg;
    logic [BW-1:0]    bcnt;
    logic [3:0]       gcnt;
`ifdef SER_PARITY_BIT_EN
    logic             par;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:  if (in_valid) nxt = SHIFT;
`ifdef SER_PARITY_BIT_EN
            SHIFT: if (bcnt == LAST) nxt = PAR;
            PAR:   nxt = EXIT;
`else
            SHIFT: if (bcnt == LAST) nxt = EXIT;
`endif
            GAP:   if (gcnt == 4'd0) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Datapath; the gap count is loaded on the last data bit and survives PAR untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg <= '0;
            bcnt <= '0;
            gcnt <= 4'd0;
`ifdef SER_PARITY_BIT_EN
            par  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    sreg <= in_data;
                    bcnt <= '0;
`ifdef SER_PARITY_BIT_EN
                    par  <= ^in_data;
`endif
                end
                SHIFT: begin
                    sreg <= sreg >> 1;
                    bcnt <= bcnt + 1'b1;
                    if (bcnt == LAST) gcnt <= GAP_LOAD;
                end
                GAP: if (gcnt != 4'd0) gcnt <= gcnt - 4'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready    = (state == IDLE) && !reset;
        x           = 1'b0;
        x_valid     = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        busy        = 1'b0;
        unique case (state)
            SHIFT: begin
                x           = sreg[0];
                x_valid     = 1'b1;
                busy        = 1'b1;
                frame_start = (bcnt == '0);
`ifndef SER_PARITY_BIT_EN
                frame_end   = (bcnt == LAST);
`endif
            end
`ifdef SER_PARITY_BIT_EN
            PAR: begin
                x         = par;
                x_valid   = 1'b1;
                busy      = 1'b1;
                frame_end = 1'b1;
            end
`endif
            GAP:     busy = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_frame_source.sv
// Scoreboard bench for serial_frame_source: two instances (8-bit/gap 1 and 4-bit/gap 0),
// directed scenarios followed by random traffic and reset pulses.
module tb_serial_frame_source;

    localparam int NI = 2;
`ifdef SER_PARITY_BIT_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct {
        int p;
        bit b;
        bit s;
        bit e;
    } exp_t;

    exp_t q[NI][$];
    int   rf[NI];
    int   pacc[NI];
    int   cyc;
    int   n_run;
    int   n_fail;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       v0 = 1'b0;
    logic       v1 = 1'b0;
    logic [7:0] d8 = 8'h00;
    logic [3:0] d4 = 4'h0;

    logic x[NI];
    logic xv[NI];
    logic fs[NI];
    logic fe[NI];
    logic bz[NI];
    logic rdy[NI];

    serial_frame_source #(.WIDTH(8), .GAP_CYCLES(1)) u0 (
        .clk(clk), .reset(reset), .in_data(d8), .in_valid(v0),
        .in_ready(rdy[0]), .x(x[0]), .x_valid(xv[0]),
        .frame_start(fs[0]), .frame_end(fe[0]), .busy(bz[0])
    );

    serial_frame_source #(.WIDTH(4), .GAP_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .in_data(d4), .in_valid(v1),
        .in_ready(rdy[1]), .x(x[1]), .x_valid(xv[1]),
        .frame_start(fs[1]), .frame_end(fe[1]), .busy(bz[1])
    );

    always #5 clk = ~clk;

    function automatic int wof(input int i);
        return (i == 0) ? 8 : 4;
    endfunction

    function automatic int gof(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    task automatic check(input string nm, input int i,
                         input logic [31:0] act, input logic [31:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s inst%0d cycle %0d: got %0h, expected %0h",
                     nm, i, cyc, act, req);
        end
    endtask

    // Reference model: a word accepted at edge k occupies periods k..k+FL-1,
    // and the source is ready again from period k+FL+GAP.
    initial begin
        cyc = 0;
        for (int i = 0; i < NI; i++) rf[i] = 0;
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < NI; i++) begin
                int  d;
                bit  v;
                int  fl;
                exp_t e;
                d  = (i == 0) ? int'(d8) : int'(d4);
                v  = (i == 0) ? v0 : v1;
                fl = wof(i) + PB;
                if (!reset && v && (cyc - 1) >= rf[i]) begin
                    for (int b = 0; b < fl; b++) begin
                        e.p = cyc + b;
                        e.b = (b < wof(i)) ? d[b] : ^d;
                        e.s = (b == 0);
                        e.e = (b == fl - 1);
                        q[i].push_back(e);
                    end
                    rf[i] = cyc + fl + gof(i);
                end
            end
        end
    end

    // Monitor: compares every period on the falling edge.
    initial begin
        n_run  = 0;
        n_fail = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                exp_t e;
                int   a;
                if (reset) begin
                    check("reset_outs", i,
                          {x[i], xv[i], fs[i], fe[i], bz[i], rdy[i]}, 0);
                    q[i].delete();
                    rf[i] = 0;
                end else begin
                    check("in_ready", i, rdy[i], cyc >= rf[i]);
                    check("busy", i, bz[i], cyc < rf[i]);
                    if (q[i].size() > 0 && q[i][0].p == cyc) begin
                        e = q[i].pop_front();
                        check("x_valid", i, xv[i], 1);
                        check("x", i, x[i], e.b);
                        check("frame_start", i, fs[i], e.s);
                        check("frame_end", i, fe[i], e.e);
                        a = fs[i] ? int'(x[i]) : (pacc[i] ^ int'(x[i]));
                        pacc[i] = a;
`ifdef SER_PARITY_BIT_EN
                        if (e.e) check("run_parity", i, a, 0);
`endif
                    end else begin
                        check("idle_outs", i, {xv[i], x[i], fs[i], fe[i]}, 0);
                    end
                end
            end
        end
    end

    task automatic step(input bit a, input logic [7:0] da,
                        input bit b, input logic [3:0] db);
        v0 = a;
        d8 = da;
        v1 = b;
        d4 = db;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) pacc[i] = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        step(0, 8'h00, 0, 4'h0);

        step(1, 8'hA5, 1, 4'h9);
        repeat (11) step(0, 8'h00, 1, 4'h6);

        step(1, 8'h01, 0, 4'h0);
        repeat (12) step(1, 8'hFF, 0, 4'h0);
        repeat (4) step(0, 8'h00, 0, 4'h0);

        step(1, 8'h5A, 0, 4'h0);
        repeat (3) step(0, 8'h00, 0, 4'h0);
        step(1, 8'hC3, 0, 4'h0);
        repeat (12) step(0, 8'h00, 0, 4'h0);

        step(1, 8'hF0, 1, 4'hF);
        repeat (4) step(0, 8'h00, 0, 4'h0);
        reset = 1'b1;
        step(0, 8'h00, 0, 4'h0);
        reset = 1'b0;
        step(1, 8'h3C, 1, 4'h3);
        repeat (12) step(0, 8'h00, 0, 4'h0);

        repeat (3000) begin
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                step(0, 8'h00, 0, 4'h0);
                reset = 1'b0;
            end else begin
                step(1'($urandom_range(0, 1)), 8'($urandom),
                     1'($urandom_range(0, 1)), 4'($urandom));
            end
        end

        repeat (20) step(0, 8'h00, 0, 4'h0);
        for (int i = 0; i < NI; i++) check("drain", i, q[i].size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
